image_blit_engine: RTL
======================

// Module: image_blit_engine
// PURPOSE
//  Full-screen copy engine driving change_display_to_image and the VGA adapter.
//  On a start pulse it latches an image opcode, sweeps the image memory address space, and waits out the read latency.
//  It then emits one (x, y, colour, plot) write per pixel to the VGA adapter's frame buffer.
//  Sits between the game/menu controller (upstream) and the VGA adapter (downstream).
// PARAMETERS
//  WIDTH     160  screen width in pixels
//  HEIGHT    120  screen height in pixels
//  X_W       8    x coordinate width
//  Y_W       7    y coordinate width
//  ADDR_W    15   image memory address width (>= clog2(WIDTH*HEIGHT))
//  COLOUR_W  3    pixel colour width
//  OPC_W     3    image opcode width
//  RD_LAT    2    clk_in edges from mem_address change to valid pixel_in (>=1)
// PORTS
//  clk_in       in   1         system clock
//  reset        in   1         synchronous, active-high reset
//  start        in   1         request a full-screen blit; sampled only in IDLE
//  image_sel    in   OPC_W     image to blit; 0 = blank (selector returns 0)
//  opcode       out  OPC_W     image select to selector; latched at accepted start
//  mem_address  out  ADDR_W    linear pixel address to image memories
//  pixel_in     in   COLOUR_W  selector data_out for mem_address, RD_LAT later
//  x            out  X_W       pixel column to VGA adapter
//  y            out  Y_W       pixel row to VGA adapter
//  colour       out  COLOUR_W  pixel colour to VGA adapter
//  plot         out  1         write strobe to VGA adapter, one pixel per cycle
//  busy         out  1         high from accepted start until done
//  done         out  1         one-cycle pulse after last pixel plotted
// BEHAVIOUR
//  Reset: state=IDLE; opcode, mem_address, x, y, colour = 0; plot, busy, done = 0.
//   Reset has priority in every state; a blit in progress is abandoned.
//   plot is 0 the cycle after the reset edge.
//  FSM IDLE -> SWEEP -> DRAIN -> FINISH -> IDLE. N = WIDTH*HEIGHT.
//  IDLE: start=1 at edge E0 sets opcode<=image_sel, mem_address<=0, busy<=1, state<=SWEEP.
//   The internal scan counters sx/sy are set to 0.
//  SWEEP: each edge advances mem_address by 1 and sx by 1.
//   sx wraps WIDTH-1 -> 0 with sy+1.
//   mem_address=k is presented during cycle k (after edge Ek).
//   On the edge that would leave mem_address=N-1, the address holds and state<=DRAIN.
//  Pipeline: valid/sx/sy shift register of depth RD_LAT+1 tracks each issued address.
//   At edge E(k+RD_LAT+1): plot<=1, x<=sx_k, y<=sy_k, colour<=pixel_in.
//   So the first plot is high after E(RD_LAT+1) and the last (pixel N-1) after E(N+RD_LAT).
//   plot is high for exactly N consecutive cycles.
//  DRAIN: counts RD_LAT+1 edges for the pipeline to empty, then state<=FINISH.
//  FINISH: done=1 for one cycle, busy=0 on the same edge, plot=0; next state IDLE.
//   done is high after E(N+RD_LAT+1).
//  x, y, colour hold their last values while plot=0.
//  opcode is held constant from the accepted start until the next accepted start; it does not clear at done.
//  start while busy (SWEEP/DRAIN/FINISH) is ignored, not queued.
//  start high continuously re-triggers one cycle after FINISH, from IDLE.
//  Address arithmetic is incremental only (no multiplier).
//   mem_address never exceeds N-1; sx < WIDTH and sy < HEIGHT always.
// TESTING (bench params WIDTH=4, HEIGHT=3, RD_LAT=2, N=12; model memory = address[2:0] XOR opcode)
//  1 start=1 image_sel=3 at E0
//    -> opcode=3, busy=1, mem_address 0..11.
//    -> plot high after E3..E14 with (x,y) = (0,0),(1,0)..(3,2) and colour = addr^3.
//    -> done pulse after E15 only.
//  2 image_sel=0 blit -> 12 plots, all colour=0; opcode=0 retained after done.
//  3 start pulsed at E5 during a blit -> ignored; still exactly 12 plots, one done.
//  4 reset at E6 mid-sweep
//    -> plot=0, busy=0, mem_address=0, opcode=0 after E7.
//    -> a new start at E8 produces a complete 12-pixel blit.
//  5 start held high -> back-to-back blits; second busy rises one cycle after first done.
//    -> no plot gap other than DRAIN/FINISH/IDLE cycles.
//  6 default params (160x120, RD_LAT=2) -> 19200 plots, last at (159,119).
//    -> max mem_address=19199; done after E19203.

Source files
------------

// File: rtl/image_blit_engine.sv
// Full-screen copy engine: sweeps image memory and streams one
// (x, y, colour, plot) write per pixel into the VGA frame buffer.
module image_blit_engine #(
  parameter int WIDTH    = 160,
  parameter int HEIGHT   = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int ADDR_W   = 15,
  parameter int COLOUR_W = 3,
  parameter int OPC_W    = 3,
  parameter int RD_LAT   = 2
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                start,
  input  logic [OPC_W-1:0]    image_sel,
  output logic [OPC_W-1:0]    opcode,
  output logic [ADDR_W-1:0]   mem_address,
  input  logic [COLOUR_W-1:0] pixel_in,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [X_W-1:0]    XMAX = X_W'(WIDTH - 1);
  localparam int                CW   = $clog2(RD_LAT + 1) + 1;
  localparam logic [CW-1:0]     DMAX = CW'(RD_LAT);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, FINISH} state_t;

  state_t            state;
  logic [X_W-1:0]    sx;
  logic [Y_W-1:0]    sy;
  logic [CW-1:0]     dcnt;
  logic [RD_LAT-1:0] pv;
  logic [X_W-1:0]    px [RD_LAT];
  logic [Y_W-1:0]    py [RD_LAT];

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state       <= IDLE;
      opcode      <= '0;
      mem_address <= '0;
      x           <= '0;
      y           <= '0;
      colour      <= '0;
      plot        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sx          <= '0;
      sy          <= '0;
      dcnt        <= '0;
      pv          <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        px[i] <= '0;
        py[i] <= '0;
      end
    end else begin
      // coordinates ride alongside each issued address until its data lands
      pv[0] <= (state == SWEEP);
      px[0] <= sx;
      py[0] <= sy;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        px[i] <= px[i-1];
        py[i] <= py[i-1];
      end
      plot <= pv[RD_LAT-1];
      if (pv[RD_LAT-1]) begin
        x      <= px[RD_LAT-1];
        y      <= py[RD_LAT-1];
        colour <= pixel_in;
      end
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opcode      <= image_sel;
            mem_address <= '0;
            sx          <= '0;
            sy          <= '0;
            busy        <= 1'b1;
            state       <= SWEEP;
          end
        end
        SWEEP: begin
          if (mem_address == LAST) begin
            dcnt  <= '0;
            state <= DRAIN;
          end else begin
            mem_address <= mem_address + 1'b1;
            if (sx == XMAX) begin
              sx <= '0;
              sy <= sy + 1'b1;
            end else begin
              sx <= sx + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (dcnt == DMAX) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FINISH;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
